cva6_lsu_mem_responder: RTL and testbench
=========================================

# cva6_lsu_mem_responder

Memory-side responder for the CVA6 LSU shim/model pair: answers the LSU's load requests and committed stores with single-cycle response pulses after fixed, parameterised latencies. It replaces hand-sequenced `load_mem_resp_i` / `store_mem_resp_i` stimulus in the equivalence benches. One instance drives both `cva6_lsu_shim` and `cva6_lsu_model` so their memory view is identical.

## Interface
Parameters:
- `LOAD_LATENCY`, default 3: cycles from accepted load request to `load_mem_resp_o`. Legal range 1..15.
- `STORE_LATENCY`, default 2: cycles from start of store service to `store_mem_resp_o`. Legal range 1..15.
- `STORE_DEPTH`, default 2: maximum committed stores awaiting response. Legal range 1..7.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous and active-low.
- `load_req_i`  in  1  LSU `load_req_o`. Level; held high until a response is seen.
- `load_addr_i`  in  32  load address. Valid while `load_req_i` is high.
- `store_commit_i`  in  1  one-cycle pulse per committed store.
- `load_mem_resp_o`  out  1  one-cycle load response pulse.
- `load_rdata_o`  out  32  load data. Valid only while `load_mem_resp_o` is high, 0 otherwise.
- `store_mem_resp_o`  out  1  one-cycle store response pulse.
- `store_pending_o`  out  3  number of committed stores not yet answered.
- `overflow_o`  out  1  sticky error flag: a commit arrived while the store queue was full.

## Operation
Load FSM has four states: IDLE, WAIT, RESP, GAP.
- IDLE: `load_req_i` high → capture `load_addr_i`, load counter ← `LOAD_LATENCY`-1, go to WAIT. If `LOAD_LATENCY`==1, go straight to RESP.
- WAIT: decrement the counter. When it reaches 0, go to RESP. `load_req_i` is ignored in this state. A drop of `load_req_i` does not abort the load.
- RESP: `load_mem_resp_o`=1 and `load_rdata_o` = captured address XOR 32'hA5A5_A5A5. Next state is GAP.
- GAP: one cycle with `load_req_i` ignored, so a request still held high from the RESP cycle is not re-accepted. Next state is IDLE.

Store path:
- The pending counter increments on `store_commit_i` and decrements on a `store_mem_resp_o` pulse.
- Commit and response in the same cycle leave the count unchanged.
- Commit while the count equals `STORE_DEPTH` and no response fires that cycle: the commit is dropped and `overflow_o` is set. `overflow_o` clears only on reset.
- The service timer is either idle or counting.
  - Idle with count > 0: load the timer with `STORE_LATENCY`-1 and start counting.
  - Counting: on reaching 0, pulse `store_mem_resp_o` and return to idle.
  - The timer is reloaded only from idle, so back-to-back stores are answered at most every `STORE_LATENCY`+1 cycles.
- A commit into an empty queue starts service on the following cycle.

Load and store paths are fully independent. Both response pulses may fire in the same cycle.

## Timing
- Reset, asynchronous on `rst_ni` low:
  - Load FSM → IDLE.
  - Counters, timer, `store_pending_o` → 0.
  - `overflow_o`, `load_mem_resp_o`, `store_mem_resp_o` → 0; `load_rdata_o` → 0.
- Reset mid-operation discards any in-flight load and all pending stores. No response pulse is emitted for them after reset releases.
- Load: request sampled high in IDLE at cycle t → `load_mem_resp_o` high at exactly cycle t+`LOAD_LATENCY`. The earliest next acceptance is cycle t+`LOAD_LATENCY`+2.
- Store: commit at cycle t into an empty queue → `store_mem_resp_o` at cycle t+1+`STORE_LATENCY`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `LSU_MEM_RESP_STALL_EN` defined:
  - Adds input port `stall_i` (1 bit).
  - While `stall_i` is high, the load counter, the store service timer, and RESP→GAP progression all freeze, and no response pulse is emitted. A pulse that was due is delayed until the first cycle with `stall_i` low.
  - Commits are still counted during stall.
  - Intended for driving `stall_i` from an `anyseq` signal to explore variable memory latency formally.
- `LSU_MEM_RESP_STALL_EN` not defined: no `stall_i` port; latencies are exactly as stated in Timing.

## Test plan
- Default params, `load_req_i`=1 and `load_addr_i`=32'h0000_1000 at cycle 10, held until response → `load_mem_resp_o`=1 only at cycle 13 with `load_rdata_o`=32'hA5A5_B5A5. No second response while the request is held through the GAP cycle.
- `store_commit_i` pulse at cycle 5 → `store_pending_o`=1 at cycle 6, `store_mem_resp_o` pulse at cycle 8, `store_pending_o`=0 at cycle 9.
- Three commits at cycles 5, 6, 7 with `STORE_DEPTH`=2 → third commit dropped, `overflow_o`=1 from cycle 8 onward, exactly two store responses (cycles 8 and 11).
- Load request and store commit both at cycle 20 → both pulses fire and neither is lost. With `LOAD_LATENCY`=3 and `STORE_LATENCY`=2, both pulses land at cycle 23.
- `rst_ni` dropped at cycle 12 during a load accepted at cycle 10 and with 1 store pending → all outputs read 0 while reset is low, and no response pulse appears after release with `load_req_i`=0.
- With `LSU_MEM_RESP_STALL_EN`: load accepted at cycle 10, `stall_i`=1 for cycles 11–14 → `load_mem_resp_o` at cycle 17.

Source files
------------

// File: rtl/cva6_lsu_mem_responder.sv
// cva6_lsu_mem_responder
// Memory-side responder for the CVA6 LSU shim/model pair. Loads are answered
// LOAD_LATENCY cycles after acceptance with data = address ^ 32'hA5A5_A5A5.
// Committed stores are queued (up to STORE_DEPTH) and answered one at a time,
// STORE_LATENCY cycles after service starts.
// Optional feature: define LSU_MEM_RESP_STALL_EN to add a stall_i input that
// freezes both response paths. Without it, latencies are fixed.
module cva6_lsu_mem_responder #(
  parameter int unsigned LOAD_LATENCY  = 3,
  parameter int unsigned STORE_LATENCY = 2,
  parameter int unsigned STORE_DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef LSU_MEM_RESP_STALL_EN
  input  logic        stall_i,
`endif
  input  logic        load_req_i,
  input  logic [31:0] load_addr_i,
  input  logic        store_commit_i,
  output logic        load_mem_resp_o,
  output logic [31:0] load_rdata_o,
  output logic        store_mem_resp_o,
  output logic [2:0]  store_pending_o,
  output logic        overflow_o
);

  localparam logic [31:0] RDATA_MASK      = 32'hA5A5_A5A5;
  localparam logic [3:0]  LOAD_CNT_INIT   = 4'(LOAD_LATENCY - 1);
  localparam logic [3:0]  STORE_CNT_INIT  = 4'(STORE_LATENCY - 1);
  localparam logic [2:0]  DEPTH           = 3'(STORE_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } load_state_e;

  logic stall;
`ifdef LSU_MEM_RESP_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  load_state_e load_state_q;
  logic [3:0]  load_cnt_q;
  logic [31:0] load_addr_q;
  logic        load_resp_q;
  logic [31:0] load_rdata_q;

  // Load FSM: accept in IDLE, count down in WAIT, pulse on entry to RESP,
  // then one GAP cycle so a still-held request is not re-accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_state_q <= IDLE;
      load_cnt_q   <= '0;
      load_addr_q  <= '0;
      load_resp_q  <= 1'b0;
      load_rdata_q <= '0;
    end else begin
      load_resp_q  <= 1'b0;
      load_rdata_q <= '0;
      case (load_state_q)
        IDLE: begin
          if (load_req_i) begin
            load_addr_q <= load_addr_i;
            if (LOAD_LATENCY == 1 && !stall) begin
              load_state_q <= RESP;
              load_resp_q  <= 1'b1;
              load_rdata_q <= load_addr_i ^ RDATA_MASK;
            end else begin
              load_cnt_q   <= LOAD_CNT_INIT;
              load_state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // A count of 0 here only happens for a single-cycle load that was
          // stalled at acceptance; it fires as soon as the stall lifts.
          if (!stall) begin
            if (load_cnt_q <= 4'd1) begin
              load_cnt_q   <= '0;
              load_state_q <= RESP;
              load_resp_q  <= 1'b1;
              load_rdata_q <= load_addr_q ^ RDATA_MASK;
            end else begin
              load_cnt_q <= load_cnt_q - 4'd1;
            end
          end
        end
        RESP: begin
          if (!stall) begin
            load_state_q <= GAP;
          end
        end
        GAP: begin
          load_state_q <= IDLE;
        end
        default: begin
          load_state_q <= IDLE;
        end
      endcase
    end
  end

  logic [2:0] store_pend_q, store_pend_d;
  logic       overflow_q, overflow_d;
  logic       store_busy_q, store_busy_d;
  logic [3:0] store_timer_q, store_timer_d;
  logic       store_resp_q, store_resp_d;
  logic       commit_drop;
  logic       commit_ok;

  // A commit is dropped only when the queue is full and no response is
  // retiring an entry in the same cycle.
  assign commit_drop = store_commit_i && (store_pend_q == DEPTH) && !store_resp_q;
  assign commit_ok   = store_commit_i && !commit_drop;

  // Store queue occupancy and service timer; the entry being answered stays
  // counted during its pulse cycle, so service restarts only after it retires.
  always_comb begin
    store_pend_d  = store_pend_q + 3'(commit_ok) - 3'(store_resp_q);
    overflow_d    = overflow_q | commit_drop;
    store_busy_d  = store_busy_q;
    store_timer_d = store_timer_q;
    store_resp_d  = 1'b0;
    if (!stall) begin
      if (!store_busy_q) begin
        if (store_pend_q != 3'd0 && !store_resp_q) begin
          if (STORE_LATENCY == 1) begin
            store_resp_d = 1'b1;
          end else begin
            store_busy_d  = 1'b1;
            store_timer_d = STORE_CNT_INIT;
          end
        end
      end else if (store_timer_q == 4'd1) begin
        store_busy_d  = 1'b0;
        store_timer_d = '0;
        store_resp_d  = 1'b1;
      end else begin
        store_timer_d = store_timer_q - 4'd1;
      end
    end
  end

  // Store path state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_pend_q  <= '0;
      overflow_q    <= 1'b0;
      store_busy_q  <= 1'b0;
      store_timer_q <= '0;
      store_resp_q  <= 1'b0;
    end else begin
      store_pend_q  <= store_pend_d;
      overflow_q    <= overflow_d;
      store_busy_q  <= store_busy_d;
      store_timer_q <= store_timer_d;
      store_resp_q  <= store_resp_d;
    end
  end

  assign load_mem_resp_o  = load_resp_q;
  assign load_rdata_o     = load_rdata_q;
  assign store_mem_resp_o = store_resp_q;
  assign store_pending_o  = store_pend_q;
  assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Testbench for cva6_lsu_mem_responder with default parameters
// (LOAD_LATENCY=3, STORE_LATENCY=2, STORE_DEPTH=2, no stall port).
// Expected response pulses are queued when stimulus is driven and checked
// against the DUT by a negedge monitor; occupancy/flags are checked directly.
module tb_cva6_lsu_mem_responder;

  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_req_i = 1'b0;
  logic [31:0] load_addr_i = '0;
  logic        store_commit_i = 1'b0;
  logic        load_mem_resp_o;
  logic [31:0] load_rdata_o;
  logic        store_mem_resp_o;
  logic [2:0]  store_pending_o;
  logic        overflow_o;

  cva6_lsu_mem_responder dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .load_req_i       (load_req_i),
    .load_addr_i      (load_addr_i),
    .store_commit_i   (store_commit_i),
    .load_mem_resp_o  (load_mem_resp_o),
    .load_rdata_o     (load_rdata_o),
    .store_mem_resp_o (store_mem_resp_o),
    .store_pending_o  (store_pending_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } load_exp_t;

  load_exp_t lq[$];
  int        sq[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_pass = 0;
  logic      mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: every cycle, a pulse must appear exactly when the scoreboard says.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        chk("load_resp", 32'(load_mem_resp_o), 32'd1);
        chk("load_rdata", load_rdata_o, lq[0].data);
        $display("load  resp cycle %0d rdata %h", cyc, load_rdata_o);
        void'(lq.pop_front());
      end else begin
        chk("load_no_resp", 32'(load_mem_resp_o), 32'd0);
        chk("load_rdata_zero", load_rdata_o, 32'd0);
      end
      if (sq.size() > 0 && sq[0] == cyc) begin
        chk("store_resp", 32'(store_mem_resp_o), 32'd1);
        $display("store resp cycle %0d pending %0d", cyc, store_pending_o);
        void'(sq.pop_front());
      end else begin
        chk("store_no_resp", 32'(store_mem_resp_o), 32'd0);
      end
    end
  end

  task automatic push_load(input int c, input logic [31:0] d);
    load_exp_t e;
    e.cyc  = c;
    e.data = d;
    lq.push_back(e);
  endtask

  initial begin
    int t;
    logic [31:0] a;

    // Reset state.
    tick(2);
    chk("rst_load_resp", 32'(load_mem_resp_o), 32'd0);
    chk("rst_rdata", load_rdata_o, 32'd0);
    chk("rst_store_resp", 32'(store_mem_resp_o), 32'd0);
    chk("rst_pending", 32'(store_pending_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Single load held through RESP and GAP: exactly one response.
    t = cyc;
    load_req_i  = 1'b1;
    load_addr_i = 32'h0000_1000;
    push_load(t + 3, 32'hA5A5_B5A5);
    tick(5);
    load_req_i = 1'b0;
    tick(6);

    // Single store.
    t = cyc;
    store_commit_i = 1'b1;
    sq.push_back(t + 3);
    tick();
    store_commit_i = 1'b0;
    chk("st1_pending_t1", 32'(store_pending_o), 32'd1);
    tick(2);
    chk("st1_pending_t3", 32'(store_pending_o), 32'd1);
    tick();
    chk("st1_pending_t4", 32'(store_pending_o), 32'd0);
    tick(3);

    // Three commits into a depth-2 queue: third dropped, overflow set.
    t = cyc;
    store_commit_i = 1'b1;
    sq.push_back(t + 3);
    sq.push_back(t + 6);
    tick();
    chk("ovf_pending_t1", 32'(store_pending_o), 32'd1);
    tick();
    chk("ovf_pending_t2", 32'(store_pending_o), 32'd2);
    chk("ovf_flag_t2", 32'(overflow_o), 32'd0);
    tick();
    store_commit_i = 1'b0;
    chk("ovf_pending_t3", 32'(store_pending_o), 32'd2);
    chk("ovf_flag_t3", 32'(overflow_o), 32'd1);
    tick();
    chk("ovf_pending_t4", 32'(store_pending_o), 32'd1);
    tick(4);
    chk("ovf_pending_t8", 32'(store_pending_o), 32'd0);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    tick(2);

    // Load and store in the same cycle: both pulses at t+3.
    t = cyc;
    load_req_i     = 1'b1;
    load_addr_i    = 32'hDEAD_BEEF;
    store_commit_i = 1'b1;
    push_load(t + 3, 32'hDEAD_BEEF ^ MASK);
    sq.push_back(t + 3);
    tick();
    load_req_i     = 1'b0;
    store_commit_i = 1'b0;
    tick(7);

    // Back-to-back loads with address changing while in WAIT.
    t = cyc;
    load_req_i  = 1'b1;
    load_addr_i = 32'h1234_5678;
    push_load(t + 3, 32'h1234_5678 ^ MASK);
    tick();
    load_addr_i = 32'hFFFF_0000;
    tick(4);
    load_addr_i = 32'h0F0F_0F0F;
    push_load(t + 8, 32'h0F0F_0F0F ^ MASK);
    tick();
    load_req_i  = 1'b0;
    load_addr_i = 32'h0;
    tick(6);

    // Randomised single loads.
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      t = cyc;
      load_req_i  = 1'b1;
      load_addr_i = a;
      push_load(t + 3, a ^ MASK);
      tick();
      load_req_i = 1'b0;
      tick(5);
    end

    // Asynchronous reset during an in-flight load and a pending store.
    t = cyc;
    load_req_i     = 1'b1;
    load_addr_i    = 32'hCAFE_0000;
    store_commit_i = 1'b1;
    tick();
    load_req_i     = 1'b0;
    store_commit_i = 1'b0;
    chk("rst2_pending_before", 32'(store_pending_o), 32'd1);
    tick();
    rst_ni = 1'b0;
    lq.delete();
    sq.delete();
    #1;
    chk("rst2_load_resp", 32'(load_mem_resp_o), 32'd0);
    chk("rst2_rdata", load_rdata_o, 32'd0);
    chk("rst2_store_resp", 32'(store_mem_resp_o), 32'd0);
    chk("rst2_pending", 32'(store_pending_o), 32'd0);
    chk("rst2_overflow", 32'(overflow_o), 32'd0);
    tick(2);
    chk("rst2_pending_held", 32'(store_pending_o), 32'd0);
    rst_ni = 1'b1;
    tick(8);
    chk("rst2_pending_after", 32'(store_pending_o), 32'd0);
    chk("rst2_overflow_after", 32'(overflow_o), 32'd0);

    // Drain with a bound.
    for (int i = 0; i < 50 && (lq.size() != 0 || sq.size() != 0); i++) tick();
    chk("drain_load_queue", 32'(lq.size()), 32'd0);
    chk("drain_store_queue", 32'(sq.size()), 32'd0);
    tick(2);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
